// File: rtl/sig_phase_scheduler.sv
// sig_phase_scheduler: highway/farm-road intersection phase sequencer.
// The farm-road car sensor and the pedestrian button compete for the
// crossing slot. Grants alternate between them when both are waiting.
// Each phase is timed by a dwell down-counter that loads dwell-1 on entry.
// Optional emergency preemption is compiled in only when the macro
// EMG_PREEMPT_EN is defined. Otherwise emg_req is ignored.
module sig_phase_scheduler #(
    parameter int unsigned HWY_MIN_GREEN = 8,
    parameter int unsigned FWY_GREEN     = 6,
    parameter int unsigned YELLOW_T      = 2,
    parameter int unsigned ALL_RED_T     = 1,
    parameter int unsigned WALK_T        = 4,
    parameter int unsigned CW            = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car_req,
    input  logic       ped_req,
    input  logic       emg_req,
    output logic [1:0] hwy,
    output logic [1:0] fwy,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_HG  = 3'd0,
        S_HY  = 3'd1,
        S_AR1 = 3'd2,
        S_FG  = 3'd3,
        S_FY  = 3'd4,
        S_AR2 = 3'd5,
        S_WK  = 3'd6
    } state_t;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;

    localparam logic SEL_CAR = 1'b0;
    localparam logic SEL_PED = 1'b1;

    localparam logic [CW-1:0] HG_LD   = CW'(HWY_MIN_GREEN - 1);
    localparam logic [CW-1:0] FG_LD   = CW'(FWY_GREEN - 1);
    localparam logic [CW-1:0] Y_LD    = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] AR_LD   = CW'(ALL_RED_T - 1);
    localparam logic [CW-1:0] WK_LD   = CW'(WALK_T - 1);
    localparam logic [CW-1:0] T_ZERO  = CW'(0);
    localparam logic [CW-1:0] T_ONE   = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          car_pend_q, car_pend_d;
    logic          ped_pend_q, ped_pend_d;
    logic          sel_q, sel_d;     // granted requester for the current round
    logic          rr_q, rr_d;       // requester preferred on the next tie
    logic [1:0]    hwy_q, hwy_d;
    logic [1:0]    fwy_q, fwy_d;
    logic          walk_q, walk_d;
    logic [2:0]    phase_q, phase_d;

    logic          timer_zero_s;
    logic          car_any_s;
    logic          ped_any_s;
    logic          emg_s;

`ifdef EMG_PREEMPT_EN
    assign emg_s = emg_req;
`else
    // Without preemption the input is tied off and emg_s folds to zero.
    logic unused_emg_s;
    assign unused_emg_s = emg_req;
    assign emg_s        = 1'b0;
`endif

    assign timer_zero_s = (timer_q == T_ZERO);
    assign car_any_s    = car_pend_q | car_req;
    assign ped_any_s    = ped_pend_q | ped_req;

    // Next-state, dwell timer, request latching and grant arbitration.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_zero_s ? T_ZERO : (timer_q - T_ONE);
        car_pend_d = car_pend_q | (car_req & (state_q != S_FG));
        ped_pend_d = ped_pend_q | (ped_req & (state_q != S_WK));
        sel_d      = sel_q;
        rr_d       = rr_q;
        case (state_q)
            S_HG: begin
                if (emg_s) begin
                    // Min green restarts once the emergency clears.
                    timer_d = HG_LD;
                end else if (timer_zero_s && (car_any_s || ped_any_s)) begin
                    state_d = S_HY;
                    timer_d = Y_LD;
                    if (car_any_s && ped_any_s) begin
                        sel_d = rr_q;
                    end else if (car_any_s) begin
                        sel_d = SEL_CAR;
                    end else begin
                        sel_d = SEL_PED;
                    end
                    rr_d = ~sel_d;
                end else begin
                    state_d = S_HG;
                end
            end
            S_HY: begin
                if (timer_zero_s) begin
                    state_d = S_AR1;
                    timer_d = AR_LD;
                end else begin
                    state_d = S_HY;
                end
            end
            S_AR1: begin
                if (timer_zero_s) begin
                    if (emg_s) begin
                        state_d = S_AR2;
                        timer_d = AR_LD;
                    end else if (sel_q == SEL_CAR) begin
                        state_d    = S_FG;
                        timer_d    = FG_LD;
                        car_pend_d = 1'b0;
                    end else begin
                        state_d    = S_WK;
                        timer_d    = WK_LD;
                        ped_pend_d = 1'b0;
                    end
                end else begin
                    state_d = S_AR1;
                end
            end
            S_FG: begin
                if (emg_s) begin
                    state_d = S_FY;
                    timer_d = Y_LD;
                    // A grant cut short is owed to the car again.
                    if (!timer_zero_s) begin
                        car_pend_d = 1'b1;
                    end else begin
                        car_pend_d = car_pend_q;
                    end
                end else if (timer_zero_s) begin
                    state_d = S_FY;
                    timer_d = Y_LD;
                end else begin
                    state_d = S_FG;
                end
            end
            S_FY: begin
                if (timer_zero_s) begin
                    state_d = S_AR2;
                    timer_d = AR_LD;
                end else begin
                    state_d = S_FY;
                end
            end
            S_WK: begin
                if (emg_s) begin
                    state_d = S_AR2;
                    timer_d = AR_LD;
                    if (!timer_zero_s) begin
                        ped_pend_d = 1'b1;
                    end else begin
                        ped_pend_d = ped_pend_q;
                    end
                end else if (timer_zero_s) begin
                    state_d = S_AR2;
                    timer_d = AR_LD;
                end else begin
                    state_d = S_WK;
                end
            end
            S_AR2: begin
                if (timer_zero_s) begin
                    state_d = S_HG;
                    timer_d = HG_LD;
                end else begin
                    state_d = S_AR2;
                end
            end
            default: begin
                state_d = S_HG;
                timer_d = HG_LD;
            end
        endcase
    end

    // Light decode of the next state so the outputs are registered with it.
    always_comb begin
        hwy_d   = L_RED;
        fwy_d   = L_RED;
        walk_d  = 1'b0;
        phase_d = state_d;
        case (state_d)
            S_HG:    hwy_d  = L_GREEN;
            S_HY:    hwy_d  = L_YELLOW;
            S_FG:    fwy_d  = L_GREEN;
            S_FY:    fwy_d  = L_YELLOW;
            S_WK:    walk_d = 1'b1;
            default: begin
                hwy_d = L_RED;
                fwy_d = L_RED;
            end
        endcase
    end

    // State, timer, request and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HG;
            timer_q    <= HG_LD;
            car_pend_q <= 1'b0;
            ped_pend_q <= 1'b0;
            sel_q      <= SEL_CAR;
            rr_q       <= 1'b0;
            hwy_q      <= L_GREEN;
            fwy_q      <= L_RED;
            walk_q     <= 1'b0;
            phase_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            car_pend_q <= car_pend_d;
            ped_pend_q <= ped_pend_d;
            sel_q      <= sel_d;
            rr_q       <= rr_d;
            hwy_q      <= hwy_d;
            fwy_q      <= fwy_d;
            walk_q     <= walk_d;
            phase_q    <= phase_d;
        end
    end

    assign hwy   = hwy_q;
    assign fwy   = fwy_q;
    assign walk  = walk_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_sig_phase_scheduler.sv
// Testbench for sig_phase_scheduler: directed phase tables, reset
// sequences and randomized traffic against a cycle-count reference model.
module tb_sig_phase_scheduler;

`ifdef EMG_PREEMPT_EN
    localparam bit EMG_ON = 1'b1;
`else
    localparam bit EMG_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       car_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       emg_req = 1'b0;
    logic [1:0] hwy;
    logic [1:0] fwy;
    logic       walk;
    logic [2:0] phase;

    int checks   = 0;
    int failures = 0;

    sig_phase_scheduler #(
        .HWY_MIN_GREEN(8), .FWY_GREEN(6), .YELLOW_T(2),
        .ALL_RED_T(1), .WALK_T(4), .CW(4)
    ) dut (
        .clk(clk), .rst(rst), .car_req(car_req), .ped_req(ped_req),
        .emg_req(emg_req), .hwy(hwy), .fwy(fwy), .walk(walk), .phase(phase)
    );

    always #5 clk = ~clk;

    // Reference model: phase number, cycles spent in it, waiting requests.
    int m_state;
    int m_age;
    bit m_cp, m_pp, m_sel, m_rr;   // m_sel/m_rr: 0 = car, 1 = pedestrian

    function automatic int dwell(input int s);
        case (s)
            0: return 8;
            1, 4: return 2;
            2, 5: return 1;
            3: return 6;
            6: return 4;
            default: return 1;
        endcase
    endfunction

    task automatic model_step(input bit c, input bit p, input bit e, input bit r);
        int nxt;
        bit done, em, cany, pany;
        if (r) begin
            m_state = 0; m_age = 0; m_cp = 0; m_pp = 0; m_sel = 0; m_rr = 0;
            return;
        end
        em   = e && EMG_ON;
        done = (m_age + 1 >= dwell(m_state));
        cany = m_cp | c;
        pany = m_pp | p;
        nxt  = m_state;
        if (m_state != 3 && c) m_cp = 1;
        if (m_state != 6 && p) m_pp = 1;
        case (m_state)
            0: if (!em && done && (cany || pany)) begin
                   nxt   = 1;
                   m_sel = (cany && pany) ? m_rr : pany;
                   m_rr  = !m_sel;
               end
            1: if (done) nxt = 2;
            2: if (done) nxt = em ? 5 : (m_sel ? 6 : 3);
            3: if (em) begin nxt = 4; if (!done) m_cp = 1; end
               else if (done) nxt = 4;
            4: if (done) nxt = 5;
            5: if (done) nxt = 0;
            6: if (em) begin nxt = 5; if (!done) m_pp = 1; end
               else if (done) nxt = 5;
            default: nxt = 0;
        endcase
        if (nxt == 3 && m_state != 3) m_cp = 0;
        if (nxt == 6 && m_state != 6) m_pp = 0;
        if (m_state == 0 && nxt == 0 && em) m_age = 0;
        else if (nxt != m_state) m_age = 0;
        else m_age = m_age + 1;
        m_state = nxt;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Compare every output against the light pattern of phase ph.
    task automatic check_outputs(input string name, input int ph);
        int eh, ef;
        eh = (ph == 0) ? 0 : (ph == 1) ? 1 : 2;
        ef = (ph == 3) ? 0 : (ph == 4) ? 1 : 2;
        check({name, "_phase"}, {29'd0, phase}, ph);
        check({name, "_hwy"},   {30'd0, hwy},   eh);
        check({name, "_fwy"},   {30'd0, fwy},   ef);
        check({name, "_walk"},  {31'd0, walk},  (ph == 6) ? 1 : 0);
    endtask

    // Drive one cycle of inputs, advance one edge, keep the model in step.
    task automatic tick(input bit c, input bit p, input bit e, input bit r);
        car_req = c; ped_req = p; emg_req = e; rst = r;
        @(posedge clk);
        #1;
        model_step(c, p, e, r);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    typedef struct {
        bit car;
        bit ped;
        bit emg;
        int ph;
    } vec_t;

    vec_t vt[$];

    // Expand {phase, run length, ...} pairs into an idle-input vector table.
    task automatic fill(input int seq[$]);
        vt.delete();
        for (int k = 0; k + 1 < seq.size(); k += 2)
            for (int j = 0; j < seq[k + 1]; j++)
                vt.push_back('{1'b0, 1'b0, 1'b0, seq[k]});
    endtask

    task automatic run_table(input string name);
        do_reset();
        for (int i = 0; i < vt.size(); i++) begin
            check_outputs($sformatf("%s_c%0d", name, i), vt[i].ph);
            tick(vt[i].car, vt[i].ped, vt[i].emg, 1'b0);
        end
    endtask

    initial begin
        int q[$];
        bit e;

        // Idle after reset: highway green forever.
        q = '{0, 50};
        fill(q);
        run_table("idle");

        // Single car pulse, then no re-service (pend was cleared).
        q = '{0, 8, 1, 2, 2, 1, 3, 6, 4, 2, 5, 1, 0, 20};
        fill(q);
        vt[2].car = 1'b1;
        run_table("car");

        // Car and pedestrian together: car first, pedestrian next round.
        q = '{0, 8, 1, 2, 2, 1, 3, 6, 4, 2, 5, 1, 0, 8, 1, 2, 2, 1, 6, 4, 5, 1, 0, 6};
        fill(q);
        vt[1].car = 1'b1;
        vt[1].ped = 1'b1;
        run_table("both");

        // Late car after min green expired: one-edge latency.
        q = '{0, 31, 1, 2, 2, 1, 3, 6, 4, 2, 5, 1, 0, 3};
        fill(q);
        vt[30].car = 1'b1;
        run_table("late");

        // Emergency raised in the second FG cycle for 10 cycles.
`ifdef EMG_PREEMPT_EN
        q = '{0, 8, 1, 2, 2, 1, 3, 2, 4, 2, 5, 1, 0, 14, 1, 2, 2, 1, 3, 6, 4, 2, 5, 1, 0, 4};
`else
        q = '{0, 8, 1, 2, 2, 1, 3, 6, 4, 2, 5, 1, 0, 26};
`endif
        fill(q);
        vt[2].car = 1'b1;
        for (int i = 12; i < 22; i++) vt[i].emg = 1'b1;
        run_table("emg");

        // Reset during FG with a pedestrian waiting: both pends dropped.
        do_reset();
        for (int i = 0; i < 13; i++) tick(i == 2, i == 12, 1'b0, 1'b0);
        check_outputs("rstfg_pre", 3);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            check_outputs($sformatf("rstfg_idle_c%0d", i), 0);
            tick(1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Reset during FG, car held afterwards: HG lasts exactly 8 cycles.
        do_reset();
        for (int i = 0; i < 13; i++) tick(i == 2, 1'b0, 1'b0, 1'b0);
        check_outputs("rstfg2_pre", 3);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            check_outputs($sformatf("rstfg2_c%0d", i), (i < 8) ? 0 : 1);
            tick(1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Randomized traffic, emergencies and occasional resets vs. model.
        do_reset();
        e = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            check_outputs($sformatf("rand_c%0d", i), m_state);
            if ($urandom_range(0, 29) == 0) e = !e;
            tick($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, e,
                 $urandom_range(0, 399) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
